// File: rtl/led_fb_cmd_ctrl.sv
// led_fb_cmd_ctrl
//   UART command decoder that draws into a 16x8 LED frame buffer. The buffer
//   has a single access port that is shared with the panel scanner. The
//   scanner always wins arbitration. Frame-buffer accesses from the command
//   side (RD/WR/CLR) wait in place while scan_req is high.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   rx_dv      : one-cycle strobe, rx_data holds a received byte
//   rx_data    : received UART byte
//   scan_req   : scanner column-read request, held until acknowledged
//   scan_addr  : column index for the scanner read
//   scan_ack   : one-cycle acknowledge, scan_data valid
//   scan_data  : column byte, bit n is row n
//   rgb        : current draw colour {r,g,b}
//   busy       : high whenever the command FSM is not idle
//   cmd_err    : one-cycle error pulse
//
// Configuration
//   LED_FB_CMD_TIMEOUT_EN : when defined, ARG1/ARG2 give up after 65535
//                           byte-less cycles and pulse cmd_err.

module led_fb_cmd_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_data,
  input  logic       scan_req,
  input  logic [3:0] scan_addr,
  output logic       scan_ack,
  output logic [7:0] scan_data,
  output logic [2:0] rgb,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {IDLE, ARG1, ARG2, RD, WR, CLR} state_e;
  typedef enum logic [1:0] {OP_SET, OP_CLR, OP_COL} op_e;

  localparam logic [7:0] ABORT_BYTE = 8'hF5;

  state_e     state, state_nx;
  op_e        op, op_nx;
  logic [3:0] col, col_nx;
  logic [2:0] row, row_nx;
  logic [7:0] hold, hold_nx;
  logic [3:0] clr_cnt, clr_cnt_nx;
  logic [2:0] rgb_nx;
  logic       err_nx;

  logic [7:0] fb [16];
  logic [3:0] port_addr;
  logic [7:0] port_rdata;
  logic       fb_we;
  logic [7:0] fb_wdata;
  logic       abort;
  logic [7:0] row_mask;

`ifdef LED_FB_CMD_TIMEOUT_EN
  logic [15:0] to_cnt;
`endif

  assign abort    = rx_dv && (rx_data == ABORT_BYTE);
  assign busy     = (state != IDLE);
  assign row_mask = 8'd1 << row;

  // Single port address: the scanner owns it whenever it asks. Otherwise the
  // address is the clear counter in CLR, or the latched column in RD/WR.
  always_comb begin
    if (scan_req)          port_addr = scan_addr;
    else if (state == CLR) port_addr = clr_cnt;
    else                   port_addr = col;
  end

  assign port_rdata = fb[port_addr];

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_nx   = state;
    op_nx      = op;
    col_nx     = col;
    row_nx     = row;
    hold_nx    = hold;
    clr_cnt_nx = clr_cnt;
    rgb_nx     = rgb;
    err_nx     = 1'b0;
    fb_we      = 1'b0;
    fb_wdata   = hold;

    case (state)
      IDLE: begin
        if (rx_dv) begin
          case (rx_data[7:4])
            4'h0: rgb_nx = rx_data[2:0];
            4'h1: begin op_nx = OP_SET; state_nx = ARG1; end
            4'h2: begin op_nx = OP_CLR; state_nx = ARG1; end
            4'h3: begin clr_cnt_nx = 4'd0; state_nx = CLR; end
            4'h4: begin op_nx = OP_COL; state_nx = ARG1; end
            default: err_nx = (rx_data != ABORT_BYTE);
          endcase
        end
      end
      ARG1: begin
        if (rx_dv) begin
          if (abort) begin
            state_nx = IDLE;
          end else if (op == OP_COL) begin
            col_nx   = rx_data[3:0];
            state_nx = ARG2;
          end else if (rx_data[3]) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end else begin
            col_nx   = rx_data[7:4];
            row_nx   = rx_data[2:0];
            state_nx = RD;
          end
        end
      end
      ARG2: begin
        if (rx_dv) begin
          if (abort) begin
            state_nx = IDLE;
          end else begin
            hold_nx  = rx_data;
            state_nx = WR;
          end
        end
      end
      RD: begin
        // The pixel edit is folded into the read so that WR is one plain
        // write for both pixel ops and column writes.
        if (!scan_req) begin
          hold_nx  = (op == OP_SET) ? (port_rdata | row_mask)
                                    : (port_rdata & ~row_mask);
          state_nx = WR;
        end
      end
      WR: begin
        if (!scan_req) begin
          fb_we    = 1'b1;
          state_nx = IDLE;
        end
      end
      CLR: begin
        if (!scan_req) begin
          fb_we      = 1'b1;
          fb_wdata   = 8'h00;
          clr_cnt_nx = clr_cnt + 4'd1;
          if (clr_cnt == 4'd15) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Bytes arriving while the port-using states run: the abort byte wins
    // over a write granted in the same cycle, and any other byte is dropped.
    if (rx_dv && (state == RD || state == WR || state == CLR)) begin
      if (abort) begin
        state_nx = IDLE;
        fb_we    = 1'b0;
      end else begin
        err_nx = 1'b1;
      end
    end

`ifdef LED_FB_CMD_TIMEOUT_EN
    if ((state == ARG1 || state == ARG2) && !rx_dv && (to_cnt == 16'hFFFF)) begin
      err_nx   = 1'b1;
      state_nx = IDLE;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op        <= OP_SET;
      col       <= 4'd0;
      row       <= 3'd0;
      hold      <= 8'h00;
      clr_cnt   <= 4'd0;
      rgb       <= 3'b101;
      cmd_err   <= 1'b0;
      scan_ack  <= 1'b0;
      scan_data <= 8'h00;
    end else begin
      state    <= state_nx;
      op       <= op_nx;
      col      <= col_nx;
      row      <= row_nx;
      hold     <= hold_nx;
      clr_cnt  <= clr_cnt_nx;
      rgb      <= rgb_nx;
      cmd_err  <= err_nx;
      scan_ack <= scan_req;
      if (scan_req) scan_data <= port_rdata;
    end
  end

  // NOTE: the frame buffer must power up blank, so it is a reset register
  // array rather than an inferred RAM. A RAM cannot be cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) fb[i] <= 8'h00;
    end else if (fb_we) begin
      fb[port_addr] <= fb_wdata;
    end
  end

`ifdef LED_FB_CMD_TIMEOUT_EN
  // Counts byte-less cycles in the argument states. Any byte or any other
  // state restarts it. It wraps to 0 on the timeout cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          to_cnt <= 16'd0;
    else if ((state == ARG1 || state == ARG2) && !rx_dv)   to_cnt <= to_cnt + 16'd1;
    else                                                   to_cnt <= 16'd0;
  end
`endif

endmodule

// File: doc/led_fb_cmd_ctrl.md
LED_FB_CMD_CTRL -- requirements
Module: led_fb_cmd_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have `rx_dv`, input, 1 bit: one-cycle strobe marking a valid received UART byte.
REQ-004 SHALL have `rx_data`, input, 8 bits: received byte, valid while `rx_dv`=1.
REQ-005 SHALL have `scan_req`, input, 1 bit: panel scanner column-read request, held until acknowledged.
REQ-006 SHALL have `scan_addr`, input, 4 bits: frame-buffer column index for the scanner read.
REQ-007 SHALL have `scan_ack`, output, 1 bit: one-cycle acknowledge that `scan_data` is valid.
REQ-008 SHALL have `scan_data`, output, 8 bits: column byte; bit n is row n.
REQ-009 SHALL have `rgb`, output, 3 bits: current draw colour as {r,g,b}.
REQ-010 SHALL have `busy`, output, 1 bit: 1 in any state other than IDLE.
REQ-011 SHALL have `cmd_err`, output, 1 bit: one-cycle error pulse.

Function
REQ-012 SHALL own a 16x8 frame buffer with one access port: at most one read or write per cycle.
REQ-013 The scanner SHALL have absolute priority on the port; the command side stalls in place on any cycle where `scan_req`=1.
REQ-014 Scanner handshake: `scan_req`=1 in cycle N SHALL give `scan_ack`=1 and `scan_data`=fb[`scan_addr`] in cycle N+1.
REQ-015 `scan_ack` SHALL be 0 in every cycle not described by REQ-014.
REQ-016 The FSM states SHALL be IDLE, ARG1, ARG2, RD, WR and CLR.
REQ-017 In IDLE, on `rx_dv`, dispatch on `rx_data[7:4]` (REQ-018 to REQ-023).
REQ-018 0x0: `rgb` <= `rx_data[2:0]`; stay in IDLE.
REQ-019 0x1 (set pixel) and 0x2 (clear pixel): go to ARG1.
REQ-020 0x3 (clear screen): go to CLR with the clear counter = 0.
REQ-021 0x4 (column write): go to ARG1.
REQ-022 Byte 0xF5: no operation; stay in IDLE.
REQ-023 Any other byte: pulse `cmd_err` for one cycle; stay in IDLE.
REQ-024 ARG1 for a pixel op: the byte is {col[3:0], 0, row[2:0]}; go to RD. If bit3=1, pulse `cmd_err` and return to IDLE.
REQ-025 ARG1 for a column write: latch `rx_data[3:0]` as the column; go to ARG2.
REQ-026 ARG2: on the next `rx_dv`, latch the data byte; go to WR.
REQ-027 RD: one granted cycle reads the column into a holding register; go to WR.
REQ-028 WR: one granted cycle writes the holding register with the row bit set or cleared (pixel op), or the data byte (column write); return to IDLE.
REQ-029 CLR: each granted cycle writes 0 to column k, then k <= k+1; after column 15 is written, return to IDLE.
REQ-030 A byte of 0xF5 received in any state SHALL abort: return to IDLE next cycle with no further writes; a partial clear stays partial.
REQ-031 Any other `rx_dv` in RD, WR or CLR SHALL drop the byte and pulse `cmd_err`.
REQ-032 If `scan_req` and a command write target the same column in the same cycle, the scan SHALL return the old data and the write SHALL complete in the next free cycle.

Reset
REQ-033 While `reset_n`=0: state=IDLE, all frame-buffer bits 0, `rgb`=3'b101, `scan_ack`=0, `scan_data`=0, `busy`=0, `cmd_err`=0, counters and holding registers 0.
REQ-034 Reset asserted mid-command SHALL discard the operation; no frame-buffer write completes after reset is asserted.

Configuration
REQ-035 The macro LED_FB_CMD_TIMEOUT_EN SHALL select an argument timeout.
REQ-036 With LED_FB_CMD_TIMEOUT_EN defined: a 16-bit counter runs in ARG1/ARG2 and clears on each `rx_dv`. At 65535 cycles without a byte, pulse `cmd_err` and return to IDLE.
REQ-037 Without LED_FB_CMD_TIMEOUT_EN: ARG1/ARG2 wait indefinitely, and no counter logic is present.

Verification
REQ-038 The bench SHALL cover: after reset, `scan_req` with addr=5 -> `scan_ack` next cycle, `scan_data`=0x00, `rgb`=3'b101.
REQ-039 The bench SHALL cover: bytes 0x10, 0x53, then read col 5 -> 0x08; then 0x20, 0x53 -> col 5 reads 0x00.
REQ-040 The bench SHALL cover: bytes 0x40, 0x0A, 0xA5 with `scan_req` held high for 10 cycles -> the write lands only after `scan_req` drops; col 10 then reads 0xA5.
REQ-041 The bench SHALL cover: fill all columns with 0xFF, send 0x30, then 0xF5 while columns 0-3 are cleared -> columns 0-3 read 0x00, columns 4-15 read 0xFF, `busy`=0.
REQ-042 The bench SHALL cover: bytes 0x07, then 0x9C -> `rgb`=3'b111; one-cycle `cmd_err` pulse; state stays IDLE.
REQ-043 The bench SHALL cover, with LED_FB_CMD_TIMEOUT_EN: byte 0x10 then 65535 idle cycles -> `cmd_err` pulse, `busy`=0.
